demux_1x2_stream: RTL
=====================

DEMUX_1X2_STREAM -- requirements
Module: demux_1x2_stream

Interface
REQ-001 Parameter WIDTH, default 8, payload bit width.
REQ-002 Parameter CNT_W, default 8, packet counter width.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port s  input  1  select for a new packet: 0 routes to port y0, 1 routes to port y1.
REQ-006 Port in_valid  input  1  input beat valid.
REQ-007 Port in_data  input  WIDTH  input beat payload.
REQ-008 Port in_last  input  1  marks the final beat of a packet.
REQ-009 Port in_ready  output  1  block accepts the beat this cycle.
REQ-010 Ports y0_valid, y1_valid  output  1  output beat valid.
REQ-011 Ports y0_data, y1_data  output  WIDTH  output payload.
REQ-012 Ports y0_last, y1_last  output  1  output last-beat flag.
REQ-013 Ports y0_ready, y1_ready  input  1  downstream accepts the beat.
REQ-014 Ports pkt_cnt0, pkt_cnt1  output  CNT_W  count of complete packets delivered on each port.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer on port p SHALL occur when yp_valid && yp_ready.
REQ-016 The FSM SHALL have states IDLE, LOCK0 and LOCK1.
REQ-017 The routed port SHALL be s in IDLE, 0 in LOCK0 and 1 in LOCK1.
REQ-018 In LOCK0 and LOCK1, s SHALL be ignored.
REQ-019 IDLE: an input transfer with in_last=0 SHALL move the FSM to LOCK<s>; with in_last=1, the FSM SHALL stay in IDLE.
REQ-020 LOCKp: an input transfer with in_last=1 SHALL return the FSM to IDLE; otherwise the FSM SHALL stay in LOCKp.
REQ-021 Each output port SHALL be a one-entry register slot (valid, data, last).
REQ-022 in_ready SHALL equal (!yp_valid || yp_ready) for the routed port p (combinational, no dependence on in_valid).
REQ-023 On an input transfer, the routed slot SHALL load in_data and in_last and set valid on the next edge, giving exactly 1 cycle of latency.
REQ-024 A slot SHALL clear valid after an output transfer unless it loads on the same edge; a simultaneous drain and load SHALL keep valid=1 with the new beat.
REQ-025 The slot data and last outputs SHALL hold stable while valid=1 and ready=0.
REQ-026 The non-routed slot SHALL drain independently and SHALL never load.
REQ-027 pkt_cnt<p> SHALL increment by 1 on each output transfer with yp_last=1, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 No beat SHALL be dropped or duplicated, and beats of one packet SHALL never be split across ports.

Reset
REQ-029 While rst=1, the block SHALL hold state IDLE, y0_valid=y1_valid=0, y*_data=0, y*_last=0, and pkt_cnt0=pkt_cnt1=0; in_ready then follows REQ-022 and equals 1.
REQ-030 Reset asserted mid-packet SHALL discard the partial packet and buffered beats; the first beat after reset SHALL be treated as a new packet.

Structure
REQ-031 Package demux_pkg SHALL hold the state enum type (IDLE, LOCK0, LOCK1) and constants DEFAULT_WIDTH=8 and DEFAULT_CNT_W=8.
REQ-032 The sub-module demux_out_slot (one-entry register with valid, data, last, load and drain) SHALL be instantiated twice.
REQ-033 The FSM and counters SHALL reside in the top module.

Verification
REQ-034 Single-beat packet: s=1, in_data=8'hA5, in_last=1, y1_ready=1 -> y1_valid=1 with data A5 one cycle later, y0_valid stays 0, pkt_cnt1=1, FSM in IDLE.
REQ-035 Packet lock: a 3-beat packet 11,22,33 with s=0 on beat 1 and s=1 on beats 2-3 -> all three beats appear on y0 in order, pkt_cnt0=1.
REQ-036 Backpressure: y0_ready=0 with the slot full -> in_ready=0, y0_data held at 44; y0_ready=1 with a new beat 55 presented -> 44 and 55 transfer on consecutive cycles with no bubble.
REQ-037 Independent drain: y1 holds beat 66 with y1_ready=0 while a packet is routed to y0 -> y0 beats flow and y1 keeps 66 until y1_ready=1.
REQ-038 Counter wrap: deliver 256 single-beat packets to y0 -> pkt_cnt0 returns to 0.
REQ-039 Reset mid-packet: assert rst after beat 2 of a 4-beat packet -> all valids=0, counters=0, FSM in IDLE; the next packet routes per s.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1x2 packet demultiplexer.
//   state_t        : routing FSM state encoding
//   DEFAULT_WIDTH  : default payload width
//   DEFAULT_CNT_W  : default packet counter width
package demux_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register slot (valid, data, last).
//   clk, rst              : clock, async active-high reset
//   load                  : capture load_data/load_last and set valid
//   load_data, load_last  : beat to capture
//   ready                 : downstream accepts the held beat
//   valid, data, last     : held beat presented downstream
module demux_out_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_last,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             last
);

   logic drain;

   assign drain = valid && ready;

   // A load on the same edge as a drain wins, so the slot stays full with the
   // new beat. data/last only change on load, so they hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         last  <= load_last;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1x2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer. The first beat of a packet picks
// the output port from s; the rest of the packet follows it regardless of s.
//   clk, rst                      : clock, async active-high reset
//   s                             : port select for a new packet (0 -> y0, 1 -> y1)
//   in_valid, in_data, in_last    : input stream
//   in_ready                      : input beat accepted this cycle
//   y0_valid/data/last, y0_ready  : output stream 0
//   y1_valid/data/last, y1_ready  : output stream 1
//   pkt_cnt0, pkt_cnt1            : complete packets delivered per port (wrapping)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | between packets; routed port follows s
// LOCK0 | mid-packet locked to y0; s ignored until in_last accepted
// LOCK1 | mid-packet locked to y1; s ignored until in_last accepted
module demux_1x2_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             y0_valid,
   output logic [WIDTH-1:0] y0_data,
   output logic             y0_last,
   input  logic             y0_ready,
   output logic             y1_valid,
   output logic [WIDTH-1:0] y1_data,
   output logic             y1_last,
   input  logic             y1_ready,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1
);

   state_t state;
   state_t state_nxt;
   logic   route;
   logic   in_xfer;
   logic   load0;
   logic   load1;

   always_comb begin
      route = 1'b0;
      case (state)
         IDLE:    route = s;
         LOCK0:   route = 1'b0;
         LOCK1:   route = 1'b1;
         default: route = 1'b0;
      endcase
   end

   // Ready looks only at the routed slot, never at in_valid.
   assign in_ready = route ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
   assign in_xfer  = in_valid && in_ready;
   assign load0    = in_xfer && !route;
   assign load1    = in_xfer && route;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_xfer && !in_last)
               state_nxt = s ? LOCK1 : LOCK0;
         end
         LOCK0, LOCK1: begin
            if (in_xfer && in_last)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .load      (load0),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (y0_ready),
      .valid     (y0_valid),
      .data      (y0_data),
      .last      (y0_last)
   );

   demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .load      (load1),
      .load_data (in_data),
      .load_last (in_last),
      .ready     (y1_ready),
      .valid     (y1_valid),
      .data      (y1_data),
      .last      (y1_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (y0_valid && y0_ready && y0_last)
            pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
         if (y1_valid && y1_ready && y1_last)
            pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
   end

endmodule
